hazard_stall_ctrl: RTL

- Central pipeline sequencing controller for the 5-stage core.
- Generates the freez/flush controls for PC, IF/ID, ID/EXE (the freez/flush register bank) and EXE/MEM.
- Handles three conditions: data hazards (stall plus bubble insertion), taken-branch squashing, and multi-cycle SRAM access in the MEM stage (global freeze).
- Keeps saturating stall performance counters.

---
 rtl/hazard_stall_ctrl_if.sv | 40 ++++
 rtl/hazard_stall_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-to-sequencer signal bundle for hazard_stall_ctrl; master is the pipeline, slave the controller.
// Level-sampled every clock: no valid/ready, each input is taken as current pipeline contents, each output acts that cycle.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_src1;
    logic [4:0]       id_src2;
    logic             id_two_regs;
    logic [4:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [4:0]       mem_dest;
    logic             mem_wb_en;
    logic             mem_access;
    logic             exe_branch_taken;

    logic             pc_freez;
    logic             ifid_freez;
    logic             ifid_flush;
    logic             idexe_freez;
    logic             idexe_flush;
    logic             exmem_freez;
    logic [CNT_W-1:0] hazard_stall_cnt;
    logic [CNT_W-1:0] mem_wait_cnt;
    logic [1:0]       fsm_state;

    modport master (
        output id_src1, id_src2, id_two_regs, exe_dest, exe_wb_en, exe_mem_read,
               mem_dest, mem_wb_en, mem_access, exe_branch_taken,
        input  pc_freez, ifid_freez, ifid_flush, idexe_freez, idexe_flush, exmem_freez,
               hazard_stall_cnt, mem_wait_cnt, fsm_state
    );

    modport slave (
        input  id_src1, id_src2, id_two_regs, exe_dest, exe_wb_en, exe_mem_read,
               mem_dest, mem_wb_en, mem_access, exe_branch_taken,
        output pc_freez, ifid_freez, ifid_flush, idexe_freez, idexe_flush, exmem_freez,
               hazard_stall_cnt, mem_wait_cnt, fsm_state
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Freeze/flush sequencer for the 5-stage core: data hazards, taken branches, multi-cycle SRAM freeze.
// Optional macro FORWARDING_EN: only EXE load-use raises a data hazard.
module hazard_stall_ctrl #(
    parameter int MEM_WAIT_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic              clock,
    input  logic              reset,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT =
        (MEM_WAIT_CYCLES >= 2) ? 4'(MEM_WAIT_CYCLES - 2) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       wcnt;
    logic [3:0]       wcnt_nxt;
    logic             mem_frz;
    logic             hz1;
    logic             hz2;
    logic             hazard;
    logic             hazard_stall;
    logic [CNT_W-1:0] hz_cnt;
    logic [CNT_W-1:0] mw_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // The cycle that detects the access is itself frozen, so MEM_WAIT only covers the remainder.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        mem_frz   = 1'b0;
        case (state)
            RUN: begin
                if (bus.mem_access) begin
                    mem_frz = 1'b1;
                    if (MEM_WAIT_CYCLES == 1) begin
                        state_nxt = MEM_DONE;
                    end else begin
                        state_nxt = MEM_WAIT;
                        wcnt_nxt  = WAIT_INIT;
                    end
                end
            end
            MEM_WAIT: begin
                mem_frz = 1'b1;
                if (wcnt == 4'd0) begin
                    state_nxt = MEM_DONE;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            MEM_DONE: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        hz1 = 1'b0;
        hz2 = 1'b0;
`ifdef FORWARDING_EN
        // Forwarding covers everything except a load whose data is not yet out of MEM.
        if (bus.exe_mem_read && bus.exe_wb_en) begin
            hz1 = (bus.id_src1 != 5'd0) && (bus.id_src1 == bus.exe_dest);
            hz2 = bus.id_two_regs && (bus.id_src2 != 5'd0) && (bus.id_src2 == bus.exe_dest);
        end
`else
        hz1 = (bus.id_src1 != 5'd0) &&
              ((bus.exe_wb_en && (bus.id_src1 == bus.exe_dest)) ||
               (bus.mem_wb_en && (bus.id_src1 == bus.mem_dest)));
        hz2 = bus.id_two_regs && (bus.id_src2 != 5'd0) &&
              ((bus.exe_wb_en && (bus.id_src2 == bus.exe_dest)) ||
               (bus.mem_wb_en && (bus.id_src2 == bus.mem_dest)));
`endif
        hazard = hz1 || hz2;
    end

    assign hazard_stall = !reset && !mem_frz && !bus.exe_branch_taken && hazard;

    always_comb begin
        bus.pc_freez    = 1'b0;
        bus.ifid_freez  = 1'b0;
        bus.ifid_flush  = 1'b0;
        bus.idexe_freez = 1'b0;
        bus.idexe_flush = 1'b0;
        bus.exmem_freez = 1'b0;
        if (reset) begin
            bus.ifid_flush  = 1'b1;
            bus.idexe_flush = 1'b1;
        end else if (mem_frz) begin
            bus.pc_freez    = 1'b1;
            bus.ifid_freez  = 1'b1;
            bus.idexe_freez = 1'b1;
            bus.exmem_freez = 1'b1;
        end else if (bus.exe_branch_taken) begin
            // The dependent ID instruction is squashed, so a coincident hazard is moot.
            bus.ifid_flush  = 1'b1;
            bus.idexe_flush = 1'b1;
        end else if (hazard) begin
            bus.pc_freez    = 1'b1;
            bus.ifid_freez  = 1'b1;
            bus.idexe_flush = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hz_cnt <= '0;
            mw_cnt <= '0;
        end else begin
            if (hazard_stall && (hz_cnt != CNT_MAX)) begin
                hz_cnt <= hz_cnt + 1'b1;
            end
            if (mem_frz && (mw_cnt != CNT_MAX)) begin
                mw_cnt <= mw_cnt + 1'b1;
            end
        end
    end

    assign bus.hazard_stall_cnt = hz_cnt;
    assign bus.mem_wait_cnt     = mw_cnt;
    assign bus.fsm_state        = state;

endmodule
